param_bank_streamer: RTL

//  Multi-channel parameter/constant bank. Per-channel reset values come from an

---
 rtl/param_bank_pkg.sv | 18 +
 rtl/param_bank_storage.sv | 31 +++
 rtl/param_bank_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/param_bank_pkg.sv
// rtl/param_bank_pkg.sv - shared state type and mask helper for param_bank_streamer
package param_bank_pkg;

    typedef enum logic [0:0] {IDLE, PRESENT} streamer_state_t;

    localparam int MAX_CHANNELS = 64;

    // Lowest set mask bit at index >= ch; returns MAX_CHANNELS when none is left.
    function automatic int next_enabled(input logic [MAX_CHANNELS-1:0] mask, input int ch);
        int found;
        found = MAX_CHANNELS;
        for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
            if (i >= ch && mask[i]) found = i;
        end
        return found;
    endfunction

endpackage

// File: rtl/param_bank_storage.sv
// rtl/param_bank_storage.sv - channel value register array with init reset, write port, async read
module param_bank_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CHANNELS = 4,
    parameter int CH_WIDTH   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUES [N_CHANNELS-1:0] = '{default: '0}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_valid_i,
    input  logic [CH_WIDTH-1:0]   wr_channel_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [CH_WIDTH-1:0]   rd_channel_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] bank_q [N_CHANNELS-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                bank_q[i] <= INIT_VALUES[i];
            end
        end else if (wr_valid_i && (int'(wr_channel_i) < N_CHANNELS)) begin
            bank_q[wr_channel_i] <= wr_data_i;
        end
    end

    assign rd_data_o = (int'(rd_channel_i) < N_CHANNELS) ? bank_q[rd_channel_i] : '0;

endmodule

// File: rtl/param_bank_streamer.sv
// rtl/param_bank_streamer.sv - parameter bank swept out as a tagged valid/ready stream
// Optional per-channel skip mask enabled by defining CHANNEL_MASK_EN.
module param_bank_streamer
    import param_bank_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int N_CHANNELS  = 4,
    parameter int DEST_WIDTH  = 8,
    parameter int BASE_DEST   = 0,
    parameter int REPETITIONS = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUES [N_CHANNELS-1:0] = '{default: '0},
    localparam int CH_WIDTH   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  trigger_i,
    input  logic                  wr_valid_i,
    input  logic [CH_WIDTH-1:0]   wr_channel_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [DEST_WIDTH-1:0] out_dest_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o
`ifdef CHANNEL_MASK_EN
    ,
    input  logic [N_CHANNELS-1:0] channel_mask_i
`endif
);

    localparam int REP_W = (REPETITIONS > 1) ? $clog2(REPETITIONS) : 1;

    if (REPETITIONS < 1) begin : g_bad_repetitions
        $error("param_bank_streamer: REPETITIONS must be at least 1");
    end
    if (N_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("param_bank_streamer: N_CHANNELS exceeds MAX_CHANNELS");
    end

    streamer_state_t       state_q, state_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [REP_W-1:0]      rep_q, rep_d, rep_next;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
    logic                  out_last_q, out_last_d;

    logic [N_CHANNELS-1:0] mask_eff;
    logic [CH_WIDTH-1:0]   first_ch, next_ch, last_ch, rd_ch;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  any_en, at_last_ch, at_last_rep, load_idle;

`ifdef CHANNEL_MASK_EN
    logic [N_CHANNELS-1:0] mask_q;

    // The live mask is used to pick the first channel on the trigger cycle itself.
    assign mask_eff = (state_q == IDLE) ? channel_mask_i : mask_q;
    assign first_ch = CH_WIDTH'(next_enabled(MAX_CHANNELS'(mask_eff), 0));
    assign next_ch  = CH_WIDTH'(next_enabled(MAX_CHANNELS'(mask_eff), int'(ch_q) + 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
        end else if (load_idle) begin
            mask_q <= channel_mask_i;
        end
    end
`else
    assign mask_eff = '1;
    assign first_ch = '0;
    assign next_ch  = ch_q + CH_WIDTH'(1);
`endif

    always_comb begin
        last_ch = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (mask_eff[i]) last_ch = CH_WIDTH'(i);
        end
    end

    assign any_en      = |mask_eff;
    assign at_last_ch  = (ch_q == last_ch);
    assign at_last_rep = (rep_q == REP_W'(REPETITIONS - 1));
    assign load_idle   = (state_q == IDLE) && trigger_i && any_en;
    assign rd_ch       = ((state_q == IDLE) || at_last_ch) ? first_ch : next_ch;
    assign rep_next    = ((state_q == PRESENT) && at_last_ch) ? rep_q + REP_W'(1) : '0;

    param_bank_storage #(
        .DATA_WIDTH  (DATA_WIDTH),
        .N_CHANNELS  (N_CHANNELS),
        .CH_WIDTH    (CH_WIDTH),
        .INIT_VALUES (INIT_VALUES)
    ) u_storage (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_valid_i   (wr_valid_i),
        .wr_channel_i (wr_channel_i),
        .wr_data_i    (wr_data_i),
        .rd_channel_i (rd_ch),
        .rd_data_o    (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        rep_d      = rep_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        out_last_d = out_last_q;
        unique case (state_q)
            IDLE: begin
                if (load_idle) begin
                    state_d    = PRESENT;
                    ch_d       = rd_ch;
                    rep_d      = '0;
                    out_data_d = rd_data;
                    out_dest_d = DEST_WIDTH'(BASE_DEST) + DEST_WIDTH'(rd_ch);
                    out_last_d = (rd_ch == last_ch) && (REPETITIONS == 1);
                end
            end
            PRESENT: begin
                if (out_ready_i) begin
                    if (at_last_ch && at_last_rep) begin
                        state_d    = IDLE;
                        out_last_d = 1'b0;
                    end else begin
                        ch_d       = rd_ch;
                        rep_d      = at_last_ch ? rep_next : rep_q;
                        out_data_d = rd_data;
                        out_dest_d = DEST_WIDTH'(BASE_DEST) + DEST_WIDTH'(rd_ch);
                        out_last_d = (rd_ch == last_ch) &&
                                     ((at_last_ch ? rep_next : rep_q) == REP_W'(REPETITIONS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            rep_q      <= '0;
            out_data_q <= '0;
            out_dest_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rep_q      <= rep_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_dest_o  = out_dest_q;
    assign out_valid_o = (state_q == PRESENT);
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == PRESENT);

endmodule
